// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues commands for a combinational 8-bit operation unit, drives its inputs,
// waits SETTLE cycles and returns the sampled result. Optional checker enabled by ALU_SEQ_CHECK_EN.
module alu_op_sequencer #(
    parameter int W      = 8,
    parameter int SEL_W  = 2,
    parameter int OP_W   = 3,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_data,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [W-1:0]     cmd_expected,
    output logic [W-1:0]     alu_input,
    output logic [SEL_W-1:0] alu_const_sel,
    output logic [OP_W-1:0]  alu_op,
    input  logic [W-1:0]     alu_output,
    input  logic             alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_status,
    output logic             rsp_mismatch,
    output logic [7:0]       err_count,
    output logic             busy
);

    // state | meaning
    // IDLE  | nothing in flight, waiting for a queued command
    // DRIVE | operands held on the unit, settle counter running
    // RESP  | response held stable until the consumer takes it
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    logic [W-1:0]     fifo_data_mem [DEPTH];
    logic [SEL_W-1:0] fifo_sel_mem  [DEPTH];
    logic [OP_W-1:0]  fifo_op_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     alu_input_q, alu_input_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_result_q, rsp_result_d;
    logic             rsp_status_q, rsp_status_d;
    logic             load, capture, handshake;

    // Count carries DEPTH+1 states so full and empty never alias.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign push      = cmd_valid && !full;
    assign pop       = load;
    assign cmd_ready = !full && !reset;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_mem[wr_ptr_q] <= cmd_data;
            fifo_sel_mem[wr_ptr_q]  <= cmd_sel;
            fifo_op_mem[wr_ptr_q]   <= cmd_op;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_input_d  = alu_input_q;
        alu_sel_d    = alu_sel_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        load         = 1'b0;
        capture      = 1'b0;
        handshake    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture      = 1'b1;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_output;
                    rsp_status_d = alu_status;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake   = 1'b1;
                    rsp_valid_d = 1'b0;
                    // Back-to-back: the next queued command starts on the handshake edge.
                    if (!empty) begin
                        load    = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            alu_input_d = fifo_data_mem[rd_ptr_q];
            alu_sel_d   = fifo_sel_mem[rd_ptr_q];
            alu_op_d    = fifo_op_mem[rd_ptr_q];
            cnt_d       = CNT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_input_q  <= '0;
            alu_sel_q    <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_input_q  <= alu_input_d;
            alu_sel_q    <= alu_sel_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign alu_input     = alu_input_q;
    assign alu_const_sel = alu_sel_q;
    assign alu_op        = alu_op_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_status    = rsp_status_q;
    assign busy          = (state_q != IDLE) || !empty;

`ifdef ALU_SEQ_CHECK_EN
    logic [W-1:0] fifo_exp_mem [DEPTH];
    logic [W-1:0] exp_q, exp_d;
    logic         rsp_mismatch_q, rsp_mismatch_d;
    logic [7:0]   err_count_q, err_count_d;

    always_ff @(posedge clk) begin
        if (push) fifo_exp_mem[wr_ptr_q] <= cmd_expected;
    end

    always_comb begin
        exp_d          = load ? fifo_exp_mem[rd_ptr_q] : exp_q;
        rsp_mismatch_d = capture ? (alu_output != exp_q) : rsp_mismatch_q;
        err_count_d    = err_count_q;
        if (handshake && rsp_mismatch_q && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q          <= '0;
            rsp_mismatch_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            exp_q          <= exp_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            err_count_q    <= err_count_d;
        end
    end

    assign rsp_mismatch = rsp_mismatch_q;
    assign err_count    = err_count_q;
`else
    logic unused_check;
    assign unused_check = ^{cmd_expected, capture, handshake};
    assign rsp_mismatch = 1'b0;
    assign err_count    = 8'd0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus hand-written multi-cycle sequences.
// A second instance runs with SETTLE=3 for the settle-timing and reset-in-DRIVE cases.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_status, rsp_mismatch, busy, alu_status;
    logic [7:0] cmd_data, cmd_expected, alu_input, alu_output, rsp_result, err_count;
    logic [1:0] cmd_sel, alu_const_sel;
    logic [2:0] cmd_op, alu_op;

    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_status3, rsp_mismatch3, busy3, alu_status3;
    logic [7:0] cmd_data3, cmd_expected3, alu_input3, alu_output3, rsp_result3, err_count3;
    logic [1:0] cmd_sel3, alu_const_sel3;
    logic [2:0] cmd_op3, alu_op3;

    // Stub operation unit
    assign alu_output  = alu_input ^ {6'b0, alu_const_sel};
    assign alu_status  = (alu_output == 8'h00);
    assign alu_output3 = alu_input3 ^ {6'b0, alu_const_sel3};
    assign alu_status3 = (alu_output3 == 8'h00);

    alu_op_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_op(cmd_op), .cmd_expected(cmd_expected),
        .alu_input(alu_input), .alu_const_sel(alu_const_sel), .alu_op(alu_op),
        .alu_output(alu_output), .alu_status(alu_status), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_status(rsp_status),
        .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
    );

    alu_op_sequencer #(.SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_data(cmd_data3), .cmd_sel(cmd_sel3), .cmd_op(cmd_op3), .cmd_expected(cmd_expected3),
        .alu_input(alu_input3), .alu_const_sel(alu_const_sel3), .alu_op(alu_op3),
        .alu_output(alu_output3), .alu_status(alu_status3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .rsp_status(rsp_status3),
        .rsp_mismatch(rsp_mismatch3), .err_count(err_count3), .busy(busy3)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic [2:0] op;
        logic [7:0] expected;
        logic [7:0] res;
        logic       st;
        logic       mm;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting clock edge.
    task automatic push(input bit u3, input logic [7:0] d, input logic [1:0] s,
                        input logic [2:0] o, input logic [7:0] e);
        int n = 0;
        if (u3) begin
            cmd_valid3 = 1'b1; cmd_data3 = d; cmd_sel3 = s; cmd_op3 = o; cmd_expected3 = e;
        end else begin
            cmd_valid = 1'b1; cmd_data = d; cmd_sel = s; cmd_op = o; cmd_expected = e;
        end
        while (!(u3 ? cmd_ready3 : cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
    endtask

    task automatic wait_rsp(input bit u3, output int n);
        n = 0;
        while (!(u3 ? rsp_valid3 : rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [7:0] b2b_res[5];
        logic       b2b_st[5];
        int n, mm_total;

        vecs[0] = '{8'h07, 2'd3, 3'd1, 8'h04, 8'h04, 1'b0, 1'b0};
        vecs[1] = '{8'h02, 2'd1, 3'd2, 8'h03, 8'h03, 1'b0, 1'b0};
        vecs[2] = '{8'h02, 2'd1, 3'd2, 8'hFF, 8'h03, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 2'd0, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 2'd2, 3'd7, 8'h00, 8'hFD, 1'b0, 1'b1};
        vecs[5] = '{8'hA5, 2'd1, 3'd5, 8'hA4, 8'hA4, 1'b0, 1'b0};
        vecs[6] = '{8'h03, 2'd3, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 2'd2, 3'd3, 8'h82, 8'h82, 1'b0, 1'b0};
        b2b_res = '{8'h03, 8'h00, 8'h05, 8'h08, 8'h10};
        b2b_st  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        cmd_valid = 0; cmd_data = 0; cmd_sel = 0; cmd_op = 0; cmd_expected = 0; rsp_ready = 0;
        cmd_valid3 = 0; cmd_data3 = 0; cmd_sel3 = 0; cmd_op3 = 0; cmd_expected3 = 0; rsp_ready3 = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_input", alu_input, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        // Scenario 1: single command latency
        rsp_ready = 1'b1;
        push(0, 8'h07, 2'd3, 3'd1, 8'h04);
        chk("t1_alu_before", alu_input, 8'h00);
        @(negedge clk);
        chk("t1_alu_input", alu_input, 8'h07);
        chk("t1_alu_sel", alu_const_sel, 2'd3);
        chk("t1_alu_op", alu_op, 3'd1);
        chk("t1_rsp_valid_early", rsp_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_result", rsp_result, 8'h04);
        chk("t1_rsp_status", rsp_status, 0);
        @(negedge clk);
        chk("t1_rsp_valid_done", rsp_valid, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_alu_hold", alu_input, 8'h07);

        // Vector table
        mm_total = 0;
        for (int i = 0; i < 8; i++) begin
            push(0, vecs[i].data, vecs[i].sel, vecs[i].op, vecs[i].expected);
            wait_rsp(0, n);
            chk($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
            chk($sformatf("vec%0d_status", i), rsp_status, vecs[i].st);
            chk($sformatf("vec%0d_mismatch", i), rsp_mismatch, CHK & vecs[i].mm);
            chk($sformatf("vec%0d_alu_op", i), alu_op, vecs[i].op);
            if (vecs[i].mm) mm_total++;
            @(negedge clk);
        end
        chk("vec_err_count", err_count, CHK ? mm_total : 0);

        // Scenario 2: fill FIFO behind a stalled response, then drain back-to-back
        rsp_ready = 1'b0;
        push(0, 8'h02, 2'd1, 3'd0, 8'h03);
        push(0, 8'h03, 2'd3, 3'd0, 8'h00);
        push(0, 8'h05, 2'd0, 3'd0, 8'h05);
        push(0, 8'h0A, 2'd2, 3'd0, 8'h08);
        push(0, 8'h10, 2'd0, 3'd0, 8'h10);
        chk("t2_cmd_ready_full", cmd_ready, 0);
        chk("t2_busy", busy, 1);
        chk("t2_rsp0_valid", rsp_valid, 1);
        chk("t2_rsp0_result", rsp_result, b2b_res[0]);
        chk("t2_rsp0_status", rsp_status, b2b_st[0]);
        // Offer a command on the pop edge while full: it must be refused
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = 8'h55; cmd_sel = 2'd0; cmd_expected = 8'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t2_cmd_ready_after_pop", cmd_ready, 1);
        for (int i = 1; i < 5; i++) begin
            wait_rsp(0, n);
            chk($sformatf("t2_gap%0d", i), n, 1);
            chk($sformatf("t2_rsp%0d_result", i), rsp_result, b2b_res[i]);
            chk($sformatf("t2_rsp%0d_status", i), rsp_status, b2b_st[i]);
            @(negedge clk);
        end
        chk("t2_busy_done", busy, 0);
        chk("t2_alu_hold", alu_input, 8'h10);
        chk("t2_err_count", err_count, CHK ? mm_total : 0);

        // Scenario 3: SETTLE=3 timing
        rsp_ready3 = 1'b1;
        push(1, 8'h02, 2'd1, 3'd6, 8'h03);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3_alu_c%0d", k), alu_input3, 8'h02);
            chk($sformatf("t3_rsp_low_c%0d", k), rsp_valid3, 0);
        end
        @(negedge clk);
        chk("t3_rsp_valid", rsp_valid3, 1);
        chk("t3_rsp_result", rsp_result3, 8'h03);
        chk("t3_rsp_status", rsp_status3, 0);
        chk("t3_alu_stable", alu_input3, 8'h02);
        @(negedge clk);
        chk("t3_rsp_done", rsp_valid3, 0);

        // Scenario 5/6: error counter saturation
        for (int i = 0; i < 300; i++) push(0, 8'h02, 2'd1, 3'd0, 8'hFF);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_drain", busy, 0);
        chk("sat_err_count", err_count, CHK ? 8'hFF : 8'h00);
        chk("sat_mismatch", rsp_mismatch, CHK);
        chk("sat_result", rsp_result, 8'h03);

        // Scenario 4a: reset while a response is held
        rsp_ready = 1'b0;
        push(0, 8'h07, 2'd3, 3'd1, 8'h00);
        push(0, 8'h02, 2'd1, 3'd2, 8'h03);
        wait_rsp(0, n);
        chk("t4r_rsp_valid", rsp_valid, 1);
        reset = 1'b1;
        #1;
        chk("t4r_rsp_valid_rst", rsp_valid, 0);
        chk("t4r_rsp_result_rst", rsp_result, 0);
        chk("t4r_alu_input_rst", alu_input, 0);
        chk("t4r_alu_sel_rst", alu_const_sel, 0);
        chk("t4r_alu_op_rst", alu_op, 0);
        chk("t4r_err_count_rst", err_count, 0);
        chk("t4r_mismatch_rst", rsp_mismatch, 0);
        chk("t4r_busy_rst", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t4r_cmd_ready_rel", cmd_ready, 1);
        chk("t4r_busy_rel", busy, 0);
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4r_queue_lost", rsp_valid, 0);

        // Scenario 4b: reset while in DRIVE (SETTLE=3 instance)
        rsp_ready3 = 1'b0;
        push(1, 8'h11, 2'd2, 3'd3, 8'h00);
        push(1, 8'h22, 2'd1, 3'd4, 8'h00);
        push(1, 8'h33, 2'd0, 3'd5, 8'h00);
        chk("t4d_in_drive_alu", alu_input3, 8'h11);
        chk("t4d_in_drive_rsp", rsp_valid3, 0);
        reset = 1'b1;
        #1;
        chk("t4d_rsp_valid_rst", rsp_valid3, 0);
        chk("t4d_alu_input_rst", alu_input3, 0);
        chk("t4d_alu_sel_rst", alu_const_sel3, 0);
        chk("t4d_alu_op_rst", alu_op3, 0);
        chk("t4d_err_count_rst", err_count3, 0);
        chk("t4d_busy_rst", busy3, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t4d_cmd_ready_rel", cmd_ready3, 1);
        chk("t4d_busy_rel", busy3, 0);
        rsp_ready3 = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4d_queue_lost", rsp_valid3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
